reg_write_arbiter: RTL
======================

Name: reg_write_arbiter

Overview:
- Shares the single register-file write port between two writers: pipeline writeback (S3) and a long-latency unit (LL, e.g. mult/div).
- LL results wait in a small FIFO.
- The block exports a pending-register scoreboard to the hazard logic and a starvation stall request to the pipeline control.
- Sits between stage-3 writeback, the LL unit and the register file write port.

Parameters:
DATA_W, 32, write data width
ADDR_W, 5, register index width (2**ADDR_W registers)
DEPTH, 4, LL FIFO entries (power of 2, >=2)
STARVE_LIMIT, 8, cycles a non-empty FIFO may be denied the port before stall_req asserts

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
S3_WE  in  1  pipeline writeback enable
S3_WS  in  ADDR_W  pipeline destination register
S3_WD  in  DATA_W  pipeline write data
ll_valid  in  1  LL result valid
ll_ws  in  ADDR_W  LL destination register
ll_wd  in  DATA_W  LL write data
ll_ready  out  1  FIFO can accept
rf_we  out  1  register-file write enable (registered)
rf_ws  out  ADDR_W  register-file write select (registered)
rf_wd  out  DATA_W  register-file write data (registered)
pending  out  2**ADDR_W  bit r = a valid FIFO entry targets register r
stall_req  out  1  asks the pipeline to hold S3_WE low
proto_err  out  1  sticky protocol violation
count  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset: FIFO emptied (in-flight entries dropped); count=0; starve counter=0; rf_we=0, rf_ws=0, rf_wd=0; pending=0; stall_req=0; proto_err=0; ll_ready=0 while reset is high.
- ll_ready = (count < DEPTH) && !reset, decoded from registered count only. No combinational path from ll_valid.
- Accept when ll_valid && ll_ready.
- ll_ws==0 on an accept: handshake completes, entry discarded, not enqueued.
- Grant, evaluated each cycle:
  - Pipeline is granted if S3_WE && S3_WS!=0.
  - Otherwise the FIFO head pops if count>0.
  - Otherwise no write.
- S3_WE with S3_WS==0 counts as no pipeline request.
- Grant result appears on rf_we/rf_ws/rf_wd at the next edge (1-cycle latency).
- rf_we=0 in idle cycles; rf_ws/rf_wd hold their last value.
- Pop and push in the same cycle is allowed: count unchanged.
- An entry pushed at edge N is poppable from cycle N+1. Minimum LL accept -> rf_we latency is 2 cycles.
- Full FIFO: ll_ready=0; ll_valid is ignored.
- Pointers wrap modulo DEPTH.
- pending = OR of one-hot(addr) over valid entries, derived from registered FIFO state.
  - Set the cycle after enqueue.
  - Cleared the cycle after the last entry for that register pops.
- Starve counter:
  - +1 (saturating at STARVE_LIMIT) each cycle count>0 and the pipeline holds the port.
  - Cleared when a FIFO entry pops or count==0.
- stall_req:
  - Registered; set at the edge where the counter reaches STARVE_LIMIT.
  - Stays 1 until the edge after a FIFO pop, then clears along with the counter.
- While stall_req==1 the pipeline must keep S3_WE low.
- Violation (stall_req && S3_WE && S3_WS!=0): pipeline still wins the port (no writeback is ever dropped); proto_err set, sticky until reset.
- FIFO order preserved: LL writes reach the register file in acceptance order.

Optional Feature:
- Macro REG_WAW_SQUASH_EN.
- Defined:
  - Each cycle a pipeline write to register r is granted, every valid FIFO entry with addr==r is marked dead, so a stale LL result cannot overwrite a younger pipeline value.
  - A dead entry pops normally (one cycle, occupies the grant slot) but drives rf_we=0. It also counts as a pop for the starve counter.
  - pending excludes dead entries.
- Not defined: no squash; every enqueued entry is written in order.

Test Plan:
- Reset, then idle -> rf_we=0, ll_ready=1, count=0, pending=0, stall_req=0, proto_err=0.
- LL push (r5, 0xDEADBEEF) with S3_WE=0 -> pending[5]=1 next cycle; rf_we=1, rf_ws=5, rf_wd=0xDEADBEEF 2 cycles after accept; pending[5]=0 the cycle after the pop.
- Push 4 LL entries (r1..r4) while S3_WE=1 to r7 continuously -> count=4, ll_ready=0, a 5th ll_valid is ignored; rf_ws=7 every cycle.
- Same stimulus -> stall_req=1 after 8 denied cycles. Then S3_WE=0 -> r1..r4 written in order on 4 consecutive cycles; stall_req clears the cycle after the first pop.
- While stall_req=1, drive S3_WE=1 to r9 -> rf_ws=9 written, proto_err=1 and stays 1 until reset. Then assert reset with 3 entries queued -> count=0, pending=0 next cycle.
- REG_WAW_SQUASH_EN: enqueue r6=0x11, then pipeline writes r6=0x22 before the drain -> final rf writes show only 0x22 to r6 (dead pop has rf_we=0). Without the macro -> 0x22, then 0x11.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - register-file write port arbiter: pipeline writeback vs. queued long-latency results
// Optional build macro: REG_WAW_SQUASH_EN (pipeline writes kill older queued LL results to the same register)
module reg_write_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       S3_WE,
    input  logic [ADDR_W-1:0]          S3_WS,
    input  logic [DATA_W-1:0]          S3_WD,
    input  logic                       ll_valid,
    input  logic [ADDR_W-1:0]          ll_ws,
    input  logic [DATA_W-1:0]          ll_wd,
    output logic                       ll_ready,
    output logic                       rf_we,
    output logic [ADDR_W-1:0]          rf_ws,
    output logic [DATA_W-1:0]          rf_wd,
    output logic [2**ADDR_W-1:0]       pending,
    output logic                       stall_req,
    output logic                       proto_err,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int ST_W  = $clog2(STARVE_LIMIT+1);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ST_W-1:0]   starve_q, starve_d;
    logic              stall_q, stall_d, proto_q, proto_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_ws_q, rf_ws_d;
    logic [DATA_W-1:0] rf_wd_q, rf_wd_d;
    logic [DEPTH-1:0]  valid;
    logic [PTR_W-1:0]  offset;
    logic              pipe_req, push, pop, head_dead;

`ifdef REG_WAW_SQUASH_EN
    logic [DEPTH-1:0]  dead_q, dead_d;
`endif

    assign ll_ready  = !reset && (count_q < CNT_W'(DEPTH));
    assign pipe_req  = S3_WE && (S3_WS != '0);
    assign push      = ll_valid && ll_ready && (ll_ws != '0);
    assign pop       = !pipe_req && (count_q != '0);

`ifdef REG_WAW_SQUASH_EN
    assign head_dead = dead_q[rd_ptr_q];
`else
    assign head_dead = 1'b0;
`endif

    // Slot i is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        valid  = '0;
        offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset   = PTR_W'(i) - rd_ptr_q;
            valid[i] = {1'b0, offset} < count_q;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
`ifdef REG_WAW_SQUASH_EN
            if (valid[i] && !dead_q[i]) pending[addr_q[i]] = 1'b1;
`else
            if (valid[i]) pending[addr_q[i]] = 1'b1;
`endif
        end
    end

    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

        rf_we_d  = 1'b0;
        rf_ws_d  = rf_ws_q;
        rf_wd_d  = rf_wd_q;
        if (pipe_req) begin
            rf_we_d = 1'b1;
            rf_ws_d = S3_WS;
            rf_wd_d = S3_WD;
        end else if (pop && !head_dead) begin
            rf_we_d = 1'b1;
            rf_ws_d = addr_q[rd_ptr_q];
            rf_wd_d = data_q[rd_ptr_q];
        end

        starve_d = starve_q;
        if (pop || count_q == '0) begin
            starve_d = '0;
        end else if (pipe_req && starve_q != ST_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + ST_W'(1);
        end
        stall_d = (starve_d == ST_W'(STARVE_LIMIT));
        proto_d = proto_q || (stall_q && pipe_req);
    end

`ifdef REG_WAW_SQUASH_EN
    always_comb begin
        dead_d = dead_q;
        if (push) dead_d[wr_ptr_q] = 1'b0;
        if (pipe_req) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid[i] && addr_q[i] == S3_WS) dead_d[i] = 1'b1;
            end
        end
    end
`endif

    // Payload storage needs no reset; validity comes from the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= ll_ws;
            data_q[wr_ptr_q] <= ll_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            proto_q  <= 1'b0;
            rf_we_q  <= 1'b0;
            rf_ws_q  <= '0;
            rf_wd_q  <= '0;
`ifdef REG_WAW_SQUASH_EN
            dead_q   <= '0;
`endif
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            proto_q  <= proto_d;
            rf_we_q  <= rf_we_d;
            rf_ws_q  <= rf_ws_d;
            rf_wd_q  <= rf_wd_d;
`ifdef REG_WAW_SQUASH_EN
            dead_q   <= dead_d;
`endif
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_ws     = rf_ws_q;
    assign rf_wd     = rf_wd_q;
    assign stall_req = stall_q;
    assign proto_err = proto_q;
    assign count     = count_q;

endmodule
